// File: rtl/exfifo_host_endpoint.sv
// Host-side endpoint for the CPU exfifo link: h2c words go through a 1-entry hold into the CPU input FIFO, and CPU replies go through a 2-entry read-ahead buffer out to the host.
// Packets are PKT_WORDS long in both directions. Defining EXFIFO_WDT_EN adds a watchdog that zero-pads a stalled h2c packet.
module exfifo_host_endpoint #(
  parameter int PKT_WORDS  = 16,
  parameter int WDT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] h2c_data,
  input  logic        h2c_valid,
  output logic        h2c_ready,
  output logic [31:0] if_d,
  output logic        if_wr,
  input  logic        if_wrfull,
  input  logic [31:0] of_d,
  output logic        of_rd,
  input  logic        of_rdempty,
  output logic [31:0] c2h_data,
  output logic        c2h_valid,
  input  logic        c2h_ready,
  output logic        c2h_last,
  output logic        h2c_pkt_done,
  output logic        c2h_pkt_done,
  output logic        err_timeout
);

  localparam int IDX_W = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_WORDS - 1);

  typedef enum logic [0:0] {
    H2C_RUN = 1'b0,
    H2C_PAD = 1'b1
  } h2c_state_e;

  h2c_state_e       state_q, state_d;
  logic             hold_v_q, hold_v_d;
  logic [31:0]      hold_q, hold_d;
  logic [IDX_W-1:0] h2c_idx_q, h2c_idx_d;
  logic             h2c_acc;

`ifdef EXFIFO_WDT_EN
  localparam logic [31:0] WDT_LIMIT = 32'(WDT_CYCLES);
  logic [31:0] wdt_q, wdt_d;
`endif

  always_comb begin
    state_d      = state_q;
    hold_v_d     = hold_v_q;
    hold_d       = hold_q;
    h2c_idx_d    = h2c_idx_q;
    h2c_ready    = 1'b0;
    if_wr        = 1'b0;
    h2c_pkt_done = 1'b0;
    err_timeout  = 1'b0;
    // An empty hold means we are emitting pad words, which are zero.
    if_d         = hold_v_q ? hold_q : 32'h0;

    if (state_q == H2C_RUN) begin
      if_wr     = hold_v_q && !if_wrfull;
      h2c_ready = reset_n && (!hold_v_q || !if_wrfull);
    end else begin
      if_wr     = !if_wrfull;
    end
    h2c_acc = h2c_valid && h2c_ready;

    if (if_wr) begin
      hold_v_d     = 1'b0;
      h2c_pkt_done = (h2c_idx_q == IDX_LAST);
      h2c_idx_d    = (h2c_idx_q == IDX_LAST) ? '0 : h2c_idx_q + 1'b1;
    end
    if (h2c_acc) begin
      hold_v_d = 1'b1;
      hold_d   = h2c_data;
    end

`ifdef EXFIFO_WDT_EN
    wdt_d = wdt_q + 32'd1;
    // Only a partially delivered packet may time out; idle between packets is fine.
    if (state_q == H2C_PAD || h2c_acc || (h2c_idx_q == '0 && !hold_v_q)) begin
      wdt_d = '0;
    end else if (wdt_q >= WDT_LIMIT) begin
      wdt_d   = '0;
      state_d = H2C_PAD;
    end
    if (state_q == H2C_PAD && if_wr && h2c_idx_q == IDX_LAST) begin
      state_d     = H2C_RUN;
      err_timeout = !hold_v_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= H2C_RUN;
      hold_v_q  <= 1'b0;
      hold_q    <= '0;
      h2c_idx_q <= '0;
`ifdef EXFIFO_WDT_EN
      wdt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_v_q  <= hold_v_d;
      hold_q    <= hold_d;
      h2c_idx_q <= h2c_idx_d;
`ifdef EXFIFO_WDT_EN
      wdt_q     <= wdt_d;
`endif
    end
  end

  logic [31:0]      buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic [IDX_W-1:0] c2h_idx_q, c2h_idx_d;
  logic             c2h_pop;
  logic [1:0]       occ_after_pop;

  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    c2h_idx_d = c2h_idx_q;

    c2h_valid    = (cnt_q != 2'd0);
    c2h_data     = buf0_q;
    c2h_last     = c2h_valid && (c2h_idx_q == IDX_LAST);
    c2h_pop      = c2h_valid && c2h_ready;
    c2h_pkt_done = c2h_pop && c2h_last;

    // Credit the pop being taken this cycle so a steady drain sustains one read per cycle.
    occ_after_pop = cnt_q + {1'b0, inflight_q} - {1'b0, c2h_pop};
    of_rd         = reset_n && !of_rdempty && (occ_after_pop < 2'd2);
    inflight_d    = of_rd;
    cnt_d         = cnt_q + {1'b0, inflight_q} - {1'b0, c2h_pop};

    if (c2h_pop) begin
      buf0_d    = buf1_q;
      c2h_idx_d = (c2h_idx_q == IDX_LAST) ? '0 : c2h_idx_q + 1'b1;
    end
    if (inflight_q) begin
      if (cnt_q == 2'd0 || (cnt_q == 2'd1 && c2h_pop)) begin
        buf0_d = of_d;
      end else begin
        buf1_d = of_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      c2h_idx_q  <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      c2h_idx_q  <= c2h_idx_d;
    end
  end

endmodule

// File: tb/tb_exfifo_host_endpoint.sv
// Scoreboard bench for exfifo_host_endpoint: stimulus pushes expected words, monitor pops and compares.
module tb_exfifo_host_endpoint;
  localparam int PKT = 16;
  localparam int WDT = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] h2c_data;
  logic        h2c_valid;
  logic        h2c_ready;
  logic [31:0] if_d;
  logic        if_wr;
  logic        if_wrfull;
  logic [31:0] of_d;
  logic        of_rd;
  logic        of_rdempty;
  logic [31:0] c2h_data;
  logic        c2h_valid;
  logic        c2h_ready;
  logic        c2h_last;
  logic        h2c_pkt_done;
  logic        c2h_pkt_done;
  logic        err_timeout;

  typedef struct packed { logic [31:0] d; logic done; logic tmo; } h2c_exp_t;
  typedef struct packed { logic [31:0] d; logic last; } c2h_exp_t;

  h2c_exp_t    h2c_exp[$];
  c2h_exp_t    c2h_exp[$];
  logic [31:0] of_fifo[$];

  int checks = 0, errors = 0;
  int h2c_pos = 0, c2h_pos = 0, cyc = 0;
  int rd_cnt = 0, h2c_done_cnt = 0, c2h_done_cnt = 0, tmo_cnt = 0;
  int t1_acc = -1, t1_wr_first = -1, t1_wr_last = -1;
  bit t1_arm = 0, rnd_wf = 0, rnd_cr = 0, rd_pend = 0;
  logic [31:0] of_d_nxt = '0;
  h2c_exp_t    me;
  c2h_exp_t    mc;
  logic [31:0] mw;

  exfifo_host_endpoint #(.PKT_WORDS(PKT), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .reset_n(reset_n),
    .h2c_data(h2c_data), .h2c_valid(h2c_valid), .h2c_ready(h2c_ready),
    .if_d(if_d), .if_wr(if_wr), .if_wrfull(if_wrfull),
    .of_d(of_d), .of_rd(of_rd), .of_rdempty(of_rdempty),
    .c2h_data(c2h_data), .c2h_valid(c2h_valid), .c2h_ready(c2h_ready), .c2h_last(c2h_last),
    .h2c_pkt_done(h2c_pkt_done), .c2h_pkt_done(c2h_pkt_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: the k-th written word of a packet closes it when k == PKT-1.
  task automatic h2c_expect(input logic [31:0] d, input logic pad);
    h2c_exp.push_back('{d: d, done: (h2c_pos == PKT - 1), tmo: pad && (h2c_pos == PKT - 1)});
    h2c_pos = (h2c_pos + 1) % PKT;
  endtask

  task automatic h2c_send(input logic [31:0] d);
    h2c_valid = 1'b1;
    h2c_data  = d;
    for (int t = 0; t < 500; t++) begin
      #4;
      if (h2c_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    fail("h2c_accept_timeout");
    h2c_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (h2c_exp.size() == 0 && c2h_exp.size() == 0 && of_fifo.size() == 0) return;
    end
    fail(name);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_b({tag, "_h2c_ready"}, h2c_ready, 1'b0);
    chk_b({tag, "_if_wr"}, if_wr, 1'b0);
    chk({tag, "_if_d"}, if_d, 32'h0);
    chk_b({tag, "_of_rd"}, of_rd, 1'b0);
    chk_b({tag, "_c2h_valid"}, c2h_valid, 1'b0);
    chk({tag, "_c2h_data"}, c2h_data, 32'h0);
    chk_b({tag, "_c2h_last"}, c2h_last, 1'b0);
    chk_b({tag, "_h2c_pkt_done"}, h2c_pkt_done, 1'b0);
    chk_b({tag, "_c2h_pkt_done"}, c2h_pkt_done, 1'b0);
    chk_b({tag, "_err_timeout"}, err_timeout, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rnd_wf) if_wrfull = ($urandom_range(3) == 0);
    if (rnd_cr) c2h_ready = ($urandom_range(2) != 0);
  end

  // Output FIFO model plus monitor; samples one time unit before each rising edge.
  always @(negedge clk) begin
    of_d = rd_pend ? of_d_nxt : $urandom;
    rd_pend = 0;
    of_rdempty = (of_fifo.size() == 0);
    #4;
    cyc++;
    if (!reset_n) begin
      h2c_exp.delete();
      c2h_exp.delete();
      h2c_pos = 0;
      c2h_pos = 0;
    end else begin
      if (h2c_valid && h2c_ready) begin
        h2c_expect(h2c_data, 1'b0);
        if (t1_arm && t1_acc < 0) t1_acc = cyc;
      end
      if (if_wr) begin
        chk_b("if_wr_vs_wrfull", if_wrfull, 1'b0);
        if (h2c_exp.size() == 0) fail("if_wr_unexpected");
        else begin
          me = h2c_exp.pop_front();
          chk("if_d", if_d, me.d);
          chk_b("h2c_pkt_done", h2c_pkt_done, me.done);
          chk_b("err_timeout", err_timeout, me.tmo);
        end
        if (t1_arm) begin
          if (t1_wr_first < 0) t1_wr_first = cyc;
          t1_wr_last = cyc;
        end
        if (h2c_pkt_done) h2c_done_cnt++;
        if (err_timeout) tmo_cnt++;
      end else if (h2c_pkt_done || err_timeout) fail("h2c_pulse_without_write");

      if (c2h_valid && c2h_ready) begin
        if (c2h_exp.size() == 0) fail("c2h_unexpected");
        else begin
          mc = c2h_exp.pop_front();
          chk("c2h_data", c2h_data, mc.d);
          chk_b("c2h_last", c2h_last, mc.last);
          chk_b("c2h_pkt_done", c2h_pkt_done, mc.last);
        end
        if (c2h_pkt_done) c2h_done_cnt++;
      end else if (c2h_pkt_done) fail("c2h_done_without_pop");

      if (of_rd) begin
        rd_cnt++;
        if (of_rdempty || of_fifo.size() == 0) fail("of_rd_while_empty");
        else begin
          mw = of_fifo.pop_front();
          c2h_exp.push_back('{d: mw, last: (c2h_pos == PKT - 1)});
          c2h_pos = (c2h_pos + 1) % PKT;
          of_d_nxt = mw;
          rd_pend = 1;
          chk_b("c2h_readahead_le2", c2h_exp.size() <= 2, 1'b1);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    int base;
    int base2;
    logic [31:0] d6;
    reset_n = 1'b0; h2c_valid = 1'b0; h2c_data = '0; if_wrfull = 1'b0;
    c2h_ready = 1'b0; of_d = '0; of_rdempty = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk_all_zero("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back packet, no backpressure.
    t1_arm = 1;
    for (int i = 1; i <= PKT; i++) h2c_send(32'(i));
    h2c_valid = 1'b0;
    wait_drain("t1_drain", 200);
    t1_arm = 0;
    chk("t1_first_latency", 32'(t1_wr_first - t1_acc), 32'd1);
    chk("t1_b2b_span", 32'(t1_wr_last - t1_wr_first), 32'(PKT - 1));
    chk("t1_pkt_done", 32'(h2c_done_cnt), 32'd1);

    // Input FIFO full for 5 cycles mid-packet.
    for (int i = 0; i < 5; i++) h2c_send($urandom);
    if_wrfull = 1'b1;
    d6 = $urandom;
    h2c_valid = 1'b1;
    h2c_data = d6;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk_b("t2_ready_low", h2c_ready, 1'b0);
      chk_b("t2_no_wr", if_wr, 1'b0);
      @(negedge clk);
    end
    if_wrfull = 1'b0;
    h2c_send(d6);
    for (int i = 0; i < PKT - 6; i++) h2c_send($urandom);
    h2c_valid = 1'b0;
    wait_drain("t2_drain", 200);
    chk("t2_pkt_done", 32'(h2c_done_cnt), 32'd2);

    // Two reply packets with host ready toggling.
    base = c2h_done_cnt;
    for (int i = 0; i < 2 * PKT; i++) of_fifo.push_back($urandom);
    for (int t = 0; t < 400 && !(of_fifo.size() == 0 && c2h_exp.size() == 0); t++) begin
      c2h_ready = (t % 2 == 0);
      @(negedge clk);
    end
    c2h_ready = 1'b0;
    chk("t3_c2h_left", 32'(c2h_exp.size() + of_fifo.size()), 32'd0);
    chk("t3_pkt_done", 32'(c2h_done_cnt - base), 32'd2);

    // Host stalled: read-ahead limited to two words.
    base = rd_cnt;
    for (int i = 0; i < 40; i++) of_fifo.push_back($urandom);
    repeat (100) @(negedge clk);
    chk("t4_readahead", 32'(rd_cnt - base), 32'd2);
    c2h_ready = 1'b1;
    wait_drain("t4_drain", 300);

    // Partial packet then silence.
    base = h2c_done_cnt;
    for (int i = 0; i < 3; i++) h2c_send($urandom);
    h2c_valid = 1'b0;
`ifdef EXFIFO_WDT_EN
    for (int k = 3; k < PKT; k++) h2c_expect(32'h0, 1'b1);
    wait_drain("t5_pad_drain", WDT + 100);
    chk("t5_err_pulses", 32'(tmo_cnt), 32'd1);
`else
    repeat (WDT + 40) @(negedge clk);
    chk("t5_still_pending", 32'(h2c_exp.size()), 32'd0);
    for (int k = 3; k < PKT; k++) h2c_send($urandom);
    h2c_valid = 1'b0;
    wait_drain("t5_finish_drain", 200);
    chk("t5_err_pulses", 32'(tmo_cnt), 32'd0);
`endif
    for (int i = 0; i < PKT; i++) h2c_send($urandom);
    h2c_valid = 1'b0;
    wait_drain("t5_next_drain", 200);
    chk("t5_pkt_done", 32'(h2c_done_cnt - base), 32'd2);

    // Randomised traffic on both paths with random backpressure.
    base = h2c_done_cnt;
    rnd_wf = 1; rnd_cr = 1;
    for (int p = 0; p < 6; p++) begin
      for (int w = 0; w < PKT; w++) begin
        if ($urandom_range(3) == 0) begin
          h2c_valid = 1'b0;
          repeat ($urandom_range(2) + 1) @(negedge clk);
        end
        of_fifo.push_back($urandom);
        h2c_send($urandom);
      end
    end
    h2c_valid = 1'b0;
    wait_drain("rand_drain", 3000);
    rnd_wf = 0; rnd_cr = 0;
    if_wrfull = 1'b0; c2h_ready = 1'b0;
    chk("rand_pkt_done", 32'(h2c_done_cnt - base), 32'd6);

    // Reset in the middle of packets on both paths.
    for (int i = 0; i < 5; i++) h2c_send($urandom);
    h2c_valid = 1'b0;
    for (int i = 0; i < 10; i++) of_fifo.push_back($urandom);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #4;
    chk_all_zero("t6");
    @(negedge clk);
    reset_n = 1'b1;
    base = h2c_done_cnt;
    base2 = c2h_done_cnt;
    for (int i = 0; i < PKT; i++) h2c_send($urandom);
    h2c_valid = 1'b0;
    c2h_ready = 1'b1;
    wait_drain("t6_drain", 300);
    chk("t6_h2c_pkt_done", 32'(h2c_done_cnt - base), 32'd1);
    chk("t6_c2h_no_done", 32'(c2h_done_cnt - base2), 32'd0);

    chk("end_h2c_queue", 32'(h2c_exp.size()), 32'd0);
    chk("end_c2h_queue", 32'(c2h_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
